// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin arbiter plus registered output stage for the
// shared writeback result bus. Picks one requester per cycle, drives the data
// mux select, and holds the winning beat under a valid/ready handshake.
// Optional per-requester grant counters are built when WB_ARB_STATS_EN is defined.
module wb_bus_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 64,
    localparam int unsigned SEL_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_src
`ifdef WB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  win;
    logic [SEL_W-1:0]  ptr_nxt;
    logic              any_req;
    logic              slot_free;
    logic              capture;
    logic [DATA_W-1:0] win_data;

    // Rotating priority search: first requester at or after ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        win     = ptr;
        any_req = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req && req[SEL_W'(idx)]) begin
                any_req = 1'b1;
                win     = SEL_W'(idx);
            end
        end
    end

    // Handshake qualification, one-hot grant and next pointer.
    always_comb begin
        slot_free = ~out_valid | out_ready;
        capture   = slot_free & any_req & ~reset;
        sel       = win;
        win_data  = req_data[32'(win)*DATA_W +: DATA_W];
        ptr_nxt   = (win == LAST_IDX) ? '0 : win + SEL_W'(1);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt[i] = capture && (win == SEL_W'(i));
        end
    end

    // Output register and round-robin pointer; hold on stall, drop valid on drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_src   <= win;
            ptr       <= ptr_nxt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef WB_ARB_STATS_EN
    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: a 4-requester and a 3-requester instance share one
// clock; a transaction-level model predicts grants and output beats each cycle.
module tb_wb_bus_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req4;
    logic [255:0] d4;
    logic         rdy4;
    logic [2:0]   req3;
    logic [191:0] d3;
    logic         rdy3;

    logic [3:0]   gnt4;
    logic [1:0]   sel4;
    logic         ov4;
    logic [63:0]  od4;
    logic [1:0]   os4;
    logic [2:0]   gnt3;
    logic [1:0]   sel3;
    logic         ov3;
    logic [63:0]  od3;
    logic [1:0]   os3;
`ifdef WB_ARB_STATS_EN
    logic [63:0]  gc4;
    logic [47:0]  gc3;
`endif

    int checks = 0;
    int errors = 0;

    // model state, index 0 = 4-requester instance, 1 = 3-requester instance
    int          nreq [2] = '{4, 3};
    int          m_ptr [2];
    bit          m_valid [2];
    logic [63:0] m_data [2];
    int          m_src [2];
    int          m_cnt [4];

    always #5 clk = ~clk;

    wb_bus_arbiter #(.NUM_REQ(4), .DATA_W(64)) dut4 (
        .clk(clk), .reset(reset), .req(req4), .req_data(d4), .gnt(gnt4), .sel(sel4),
        .out_valid(ov4), .out_ready(rdy4), .out_data(od4), .out_src(os4)
`ifdef WB_ARB_STATS_EN
        , .grant_cnt(gc4)
`endif
    );

    wb_bus_arbiter #(.NUM_REQ(3), .DATA_W(64)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .req_data(d3), .gnt(gnt3), .sel(sel3),
        .out_valid(ov3), .out_ready(rdy3), .out_data(od3), .out_src(os3)
`ifdef WB_ARB_STATS_EN
        , .grant_cnt(gc3)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic bit rq(input int id, input int i);
        return (id == 0) ? req4[i] : req3[i];
    endfunction

    function automatic logic [63:0] dat(input int id, input int i);
        return (id == 0) ? d4[i*64 +: 64] : d3[i*64 +: 64];
    endfunction

    // First requester in rotated order starting at the model pointer, -1 if none.
    function automatic int exp_win(input int id);
        for (int k = 0; k < nreq[id]; k++) begin
            int idx;
            idx = (m_ptr[id] + k) % nreq[id];
            if (rq(id, idx)) return idx;
        end
        return -1;
    endfunction

    function automatic bit exp_cap(input int id);
        bit rd;
        rd = (id == 0) ? rdy4 : rdy3;
        return !reset && (!m_valid[id] || rd) && (exp_win(id) >= 0);
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            m_ptr[id] = 0; m_valid[id] = 0; m_data[id] = '0; m_src[id] = 0;
        end
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // Compare all outputs against the model, advance one clock, update the model.
    task automatic tick();
        int          w [2];
        bit          cap [2];
        logic [63:0] eg;
        for (int id = 0; id < 2; id++) begin
            w[id]   = exp_win(id);
            cap[id] = exp_cap(id);
            eg      = cap[id] ? (64'd1 << w[id]) : 64'd0;
            if (id == 0) begin
                chk("gnt4", 64'(gnt4), eg);
                if (!reset) chk("sel4", 64'(sel4), 64'((w[0] >= 0) ? w[0] : m_ptr[0]));
                chk("out_valid4", 64'(ov4), 64'(m_valid[0]));
                chk("out_data4", od4, m_data[0]);
                chk("out_src4", 64'(os4), 64'(m_src[0]));
            end else begin
                chk("gnt3", 64'(gnt3), eg);
                if (!reset) chk("sel3", 64'(sel3), 64'((w[1] >= 0) ? w[1] : m_ptr[1]));
                chk("out_valid3", 64'(ov3), 64'(m_valid[1]));
                chk("out_data3", od3, m_data[1]);
                chk("out_src3", 64'(os3), 64'(m_src[1]));
            end
        end
`ifdef WB_ARB_STATS_EN
        for (int i = 0; i < 4; i++) chk("grant_cnt4", 64'(gc4[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int id = 0; id < 2; id++) begin
                bit rd;
                rd = (id == 0) ? rdy4 : rdy3;
                if (cap[id]) begin
                    m_data[id]  = dat(id, w[id]);
                    m_src[id]   = w[id];
                    m_valid[id] = 1;
                    m_ptr[id]   = (w[id] + 1) % nreq[id];
                    if (id == 0 && m_cnt[w[id]] < 65535) m_cnt[w[id]]++;
                end else if (m_valid[id] && rd) begin
                    m_valid[id] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic rst, input logic [3:0] r4, input logic rd4,
                         input logic [2:0] r3, input logic rd3);
        reset = rst; req4 = r4; rdy4 = rd4; req3 = r3; rdy3 = rd3;
        for (int i = 0; i < 8; i++) d4[i*32 +: 32] = $urandom();
        for (int i = 0; i < 6; i++) d3[i*32 +: 32] = $urandom();
    endtask

    initial begin
        drive(1'b1, 4'b1111, 1'b1, 3'b000, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset with all requesting, then first capture goes to unit 0
        drive(1'b1, 4'b1111, 1'b1, 3'b000, 1'b1); #1;
        chk("rst_gnt", 64'(gnt4), 64'd0);
        chk("rst_valid", 64'(ov4), 64'd0);
        chk("rst_data", od4, 64'd0);
        tick();
        drive(1'b0, 4'b1111, 1'b1, 3'b000, 1'b1); #1;
        chk("first_gnt", 64'(gnt4), 64'b0001);
        tick();

        // full rotation from a fresh reset, out_src trailing gnt by one cycle
        drive(1'b1, 4'b0000, 1'b1, 3'b000, 1'b1); #1; tick();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 4'b1111, 1'b1, 3'b000, 1'b1); #1;
            chk("rr_gnt", 64'(gnt4), 64'd1 << (k % 4));
            if (k > 0) chk("rr_src", 64'(os4), 64'((k - 1) % 4));
            tick();
        end

        // pointer skips idle requesters
        drive(1'b1, 4'b0000, 1'b1, 3'b000, 1'b1); #1; tick();
        drive(1'b0, 4'b0001, 1'b1, 3'b000, 1'b1); #1;
        chk("skip_g0", 64'(gnt4), 64'b0001); tick();
        drive(1'b0, 4'b0101, 1'b1, 3'b000, 1'b1); #1;
        chk("skip_g2", 64'(gnt4), 64'b0100); tick();
        drive(1'b0, 4'b0101, 1'b1, 3'b000, 1'b1); #1;
        chk("skip_g0b", 64'(gnt4), 64'b0001); tick();
        drive(1'b0, 4'b0101, 1'b1, 3'b000, 1'b1); #1;
        chk("skip_g2b", 64'(gnt4), 64'b0100); tick();

        // stall holds output and withholds grant; release grants in the same cycle
        drive(1'b1, 4'b0000, 1'b1, 3'b000, 1'b1); #1; tick();
        drive(1'b0, 4'b0001, 1'b1, 3'b000, 1'b1);
        d4[63:0] = 64'h0000_0000_0000_A0A0; #1;
        chk("st_cap", 64'(gnt4), 64'b0001); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b0010, 1'b0, 3'b000, 1'b1); #1;
            chk("st_gnt", 64'(gnt4), 64'd0);
            chk("st_valid", 64'(ov4), 64'd1);
            chk("st_data", od4, 64'h0000_0000_0000_A0A0);
            tick();
        end
        drive(1'b0, 4'b0010, 1'b1, 3'b000, 1'b1);
        d4[127:64] = 64'h0000_0000_0000_B1B1; #1;
        chk("st_rel_gnt", 64'(gnt4), 64'b0010); tick();
        drive(1'b0, 4'b0000, 1'b1, 3'b000, 1'b1); #1;
        chk("st_new_data", od4, 64'h0000_0000_0000_B1B1);
        chk("st_new_src", 64'(os4), 64'd1);
        tick();
        drive(1'b0, 4'b0000, 1'b1, 3'b000, 1'b1); #1;
        chk("drain_valid", 64'(ov4), 64'd0);
        chk("drain_hold", od4, 64'h0000_0000_0000_B1B1);
        tick();

        // three requesters: wrap after unit 2, not at 4
        drive(1'b1, 4'b0000, 1'b1, 3'b000, 1'b1); #1; tick();
        drive(1'b0, 4'b0000, 1'b1, 3'b010, 1'b1); #1;
        chk("n3_g1", 64'(gnt3), 64'b010); tick();
        drive(1'b0, 4'b0000, 1'b1, 3'b111, 1'b1); #1;
        chk("n3_g2", 64'(gnt3), 64'b100); tick();
        drive(1'b0, 4'b0000, 1'b1, 3'b111, 1'b1); #1;
        chk("n3_wrap0", 64'(gnt3), 64'b001); tick();
        drive(1'b0, 4'b0000, 1'b1, 3'b111, 1'b1); #1;
        chk("n3_g1b", 64'(gnt3), 64'b010); tick();

        // randomized traffic with stalls and occasional mid-transfer resets
        for (int k = 0; k < 3000; k++) begin
            drive(1'($urandom_range(0, 99) == 0), 4'($urandom()), 1'($urandom_range(0, 3) != 0),
                  3'($urandom()), 1'($urandom_range(0, 2) != 0));
            #1; tick();
        end

`ifdef WB_ARB_STATS_EN
        // saturation of one counter, others untouched, then clear on reset
        drive(1'b1, 4'b0000, 1'b1, 3'b000, 1'b1); #1; tick();
        for (int k = 0; k < 70000; k++) begin
            drive(1'b0, 4'b0010, 1'b1, 3'b000, 1'b1); #1;
            if (k % 1024 == 0 || k > 65530) tick();
            else begin
                @(posedge clk);
                if (m_cnt[1] < 65535) m_cnt[1]++;
                m_valid[0] = 1; m_src[0] = 1; m_data[0] = d4[127:64]; m_ptr[0] = 2;
                m_valid[1] = 0;
                @(negedge clk);
            end
        end
        chk("sat_cnt1", 64'(gc4[31:16]), 64'hFFFF);
        chk("sat_cnt0", 64'(gc4[15:0]), 64'd0);
        chk("sat_cnt2", 64'(gc4[47:32]), 64'd0);
        drive(1'b1, 4'b0000, 1'b1, 3'b000, 1'b1); #1; tick();
        drive(1'b0, 4'b0000, 1'b1, 3'b000, 1'b1); #1;
        chk("clr_cnt", 64'(gc4), 64'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
